// File: rtl/lsu_rsp_replay.sv
// Captures master-core LSU ICB responses and replays them in order to the shadow core's AGU.
// Optional master/shadow command comparison is built when LSU_RSP_REPLAY_CMD_CHK_EN is defined.
module lsu_rsp_replay #(
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int AW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     mst_rsp_fire,
   input  logic                     mst_rsp_err,
   input  logic                     mst_rsp_excl_ok,
   input  logic [DW-1:0]            mst_rsp_rdata,
   input  logic                     mst_cmd_fire,
   input  logic [AW-1:0]            mst_cmd_addr,
   input  logic                     mst_cmd_read,
   input  logic                     shd_icb_cmd_valid,
   output logic                     shd_icb_cmd_ready,
   input  logic [AW-1:0]            shd_icb_cmd_addr,
   input  logic                     shd_icb_cmd_read,
   output logic                     shd_icb_rsp_valid,
   input  logic                     shd_icb_rsp_ready,
   output logic                     shd_icb_rsp_err,
   output logic                     shd_icb_rsp_excl_ok,
   output logic [DW-1:0]            shd_icb_rsp_rdata,
   output logic [$clog2(DEPTH):0]   rsp_cnt,
   output logic                     ovf_err,
   output logic                     cmd_mismatch
);
   localparam int          PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef struct packed {
      logic          err;
      logic          excl_ok;
      logic [DW-1:0] rdata;
   } rsp_ent_t;

   rsp_ent_t      rsp_mem [DEPTH];
   rsp_ent_t      head;
   logic [PW-1:0] wptr, rptr;
   logic [PW:0]   pend_cnt;
   logic          cmd_avail, cmd_drop, cmd_acc;
   logic          rsp_push, rsp_pop, rsp_drop;

   assign shd_icb_cmd_ready = (pend_cnt < FULL) & ~flush & cmd_avail;
   assign cmd_acc           = shd_icb_cmd_valid & shd_icb_cmd_ready;
   assign shd_icb_rsp_valid = ~flush & (pend_cnt != '0) & (rsp_cnt != '0);
   assign rsp_pop           = shd_icb_rsp_valid & shd_icb_rsp_ready;
   // a full FIFO still takes a push when its head leaves in the same cycle
   assign rsp_push          = mst_rsp_fire & ~flush & ((rsp_cnt != FULL) | rsp_pop);
   assign rsp_drop          = mst_rsp_fire & ~flush & ~rsp_push;

   assign head                = (rsp_cnt != '0) ? rsp_mem[rptr] : '0;
   assign shd_icb_rsp_err     = head.err;
   assign shd_icb_rsp_excl_ok = head.excl_ok;
   assign shd_icb_rsp_rdata   = head.rdata;

   always_ff @(posedge clk) begin
      if (rsp_push) rsp_mem[wptr] <= {mst_rsp_err, mst_rsp_excl_ok, mst_rsp_rdata};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         rsp_cnt  <= '0;
         pend_cnt <= '0;
         ovf_err  <= 1'b0;
      end else if (flush) begin
         wptr     <= '0;
         rptr     <= '0;
         rsp_cnt  <= '0;
         pend_cnt <= '0;
         ovf_err  <= 1'b0;
      end else begin
         if (rsp_push) wptr <= wptr + 1'b1;
         if (rsp_pop)  rptr <= rptr + 1'b1;
         case ({rsp_push, rsp_pop})
            2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
            2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
            default: ;
         endcase
         case ({cmd_acc, rsp_pop})
            2'b10:   pend_cnt <= pend_cnt + 1'b1;
            2'b01:   pend_cnt <= pend_cnt - 1'b1;
            default: ;
         endcase
         if (rsp_drop | cmd_drop) ovf_err <= 1'b1;
      end
   end

`ifdef LSU_RSP_REPLAY_CMD_CHK_EN
   logic [AW:0]   cmd_mem [DEPTH];
   logic [PW-1:0] cwptr, crptr;
   logic [PW:0]   ccnt;
   logic          cmd_push, mism;

   assign cmd_avail    = (ccnt != '0);
   assign cmd_push     = mst_cmd_fire & ~flush & ((ccnt != FULL) | cmd_acc);
   assign cmd_drop     = mst_cmd_fire & ~flush & ~cmd_push;
   assign cmd_mismatch = mism;

   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem[cwptr] <= {mst_cmd_read, mst_cmd_addr};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cwptr <= '0;
         crptr <= '0;
         ccnt  <= '0;
         mism  <= 1'b0;
      end else if (flush) begin
         cwptr <= '0;
         crptr <= '0;
         ccnt  <= '0;
         mism  <= 1'b0;
      end else begin
         if (cmd_push) cwptr <= cwptr + 1'b1;
         if (cmd_acc) begin
            crptr <= crptr + 1'b1;
            if (cmd_mem[crptr] != {shd_icb_cmd_read, shd_icb_cmd_addr}) mism <= 1'b1;
         end
         case ({cmd_push, cmd_acc})
            2'b10:   ccnt <= ccnt + 1'b1;
            2'b01:   ccnt <= ccnt - 1'b1;
            default: ;
         endcase
      end
   end
`else
   logic unused_cmd;
   assign cmd_avail    = 1'b1;
   assign cmd_drop     = 1'b0;
   assign cmd_mismatch = 1'b0;
   assign unused_cmd   = &{1'b0, mst_cmd_fire, mst_cmd_addr, mst_cmd_read,
                           shd_icb_cmd_addr, shd_icb_cmd_read};
`endif

endmodule

// File: doc/lsu_rsp_replay.md
Name: lsu_rsp_replay

Overview:
- Responder-side companion to the redundant-core LSU buffer stage. It captures ICB responses produced by the master core's LSU.
- It acts as the ICB responder for the shadow core's AGU command channel, replaying the captured responses in order, so the shadow core never reaches real memory.
- Flags overflow, and optionally command divergence, for the lockstep error logic.

Parameters:
- DEPTH, 4, response FIFO entries and max outstanding shadow commands; power of 2, >=2.
- DW, `E203_XLEN (32), response data width.
- AW, `E203_ADDR_SIZE (32), command address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear pulse (lockstep resync).
- mst_rsp_fire  in  1  master-core AGU ICB rsp handshake (valid&ready) this cycle.
- mst_rsp_err  in  1  master rsp error.
- mst_rsp_excl_ok  in  1  master rsp exclusive-ok.
- mst_rsp_rdata  in  DW  master rsp read data.
- mst_cmd_fire  in  1  master-core AGU ICB cmd handshake (used only with the optional feature).
- mst_cmd_addr  in  AW  master cmd address (optional feature only).
- mst_cmd_read  in  1  master cmd read flag (optional feature only).
- shd_icb_cmd_valid  in  1  shadow AGU cmd valid.
- shd_icb_cmd_ready  out  1  shadow AGU cmd ready.
- shd_icb_cmd_addr  in  AW  shadow cmd address.
- shd_icb_cmd_read  in  1  shadow cmd read flag.
- shd_icb_rsp_valid  out  1  replayed rsp valid.
- shd_icb_rsp_ready  in  1  shadow rsp ready.
- shd_icb_rsp_err  out  1  replayed error.
- shd_icb_rsp_excl_ok  out  1  replayed exclusive-ok.
- shd_icb_rsp_rdata  out  DW  replayed data.
- rsp_cnt  out  log2(DEPTH)+1  response FIFO occupancy.
- ovf_err  out  1  sticky: master rsp lost because FIFO full.
- cmd_mismatch  out  1  sticky: shadow cmd differs from master cmd (optional feature).

Behaviour:
- Reset (rst=1, async):
  - FIFO pointers, rsp_cnt, pend_cnt, ovf_err and cmd_mismatch all 0.
  - shd_icb_rsp_valid=0; shd_icb_cmd_ready=1 after reset.
  - shd_icb_rsp_* data outputs are 0 while the FIFO is empty.
- Response FIFO:
  - Entry = {err, excl_ok, rdata}, registered storage, no bypass.
  - Push when mst_rsp_fire. An entry pushed in cycle N is visible at the head in cycle N+1 at the earliest.
  - Push while full with no pop in the same cycle: entry dropped, ovf_err set, rsp_cnt unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Pointers wrap modulo DEPTH.
  - rsp_cnt = entries held, 0..DEPTH.
- Shadow command channel:
  - pend_cnt counts accepted shadow commands not yet answered, range 0..DEPTH.
  - shd_icb_cmd_ready = (pend_cnt < DEPTH) & ~flush.
  - Accept = valid & ready; pend_cnt+1.
  - Address and read are not used for replay. Data returns strictly in order.
- Shadow response channel:
  - shd_icb_rsp_valid = (pend_cnt != 0) & (rsp_cnt != 0).
  - rsp data driven combinationally from the FIFO head.
  - Pop and pend_cnt-1 on rsp valid & ready.
  - Simultaneous cmd accept and rsp handshake leaves pend_cnt unchanged.
  - Once asserted, rsp valid and payload stay stable until the handshake.
  - Master responses arriving before the matching shadow command wait in the FIFO. Shadow commands arriving first wait for data.
- flush:
  - Next edge clears pointers, rsp_cnt, pend_cnt, ovf_err and cmd_mismatch.
  - During the flush cycle: rsp valid forced 0 and cmd ready 0; any push in that cycle is discarded.
  - Flush has priority over all other events.

Optional Feature:
- Macro: LSU_RSP_REPLAY_CMD_CHK_EN.
- Defined:
  - A second DEPTH-entry FIFO holds {mst_cmd_read, mst_cmd_addr}, pushed on mst_cmd_fire. It has the same overflow rule, which also sets ovf_err.
  - shd_icb_cmd_ready additionally requires this cmd FIFO to be non-empty.
  - On shadow cmd accept, the head is popped and compared with {shd_icb_cmd_read, shd_icb_cmd_addr}. Any bit difference sets cmd_mismatch (sticky), one cycle after accept.
  - flush clears this FIFO too.
- Undefined:
  - mst_cmd_* are ignored and no cmd FIFO is built.
  - cmd_mismatch is tied to 0; ready follows the base rule.

Test Plan:
- Ordered replay: push rdata 0x11, 0x22, 0x33 with err=0; then 3 shadow cmds with rsp_ready=1 -> rsp_valid on 3 handshakes delivering 0x11, 0x22, 0x33 in order; rsp_cnt returns to 0.
- Command before data: shadow cmd accepted at cycle 0, mst_rsp_fire with 0xDEAD_BEEF, err=1 at cycle 5 -> rsp_valid first high at cycle 6 with rdata 0xDEADBEEF, err=1; pend_cnt goes 1 -> 0.
- Overflow: DEPTH=4, 5 consecutive pushes with no pops -> rsp_cnt=4, ovf_err=1 after the 5th; the 5th value is never replayed. A push+pop on a full FIFO does not set ovf_err.
- Backpressure and limit: 4 shadow cmds accepted, rsp_ready=0 -> shd_icb_cmd_ready=0 and rsp payload stable; raise rsp_ready for one cycle -> ready=1 next cycle.
- Flush and reset: 2 entries queued, pend_cnt=1, ovf_err=1, then flush pulse -> next cycle rsp_cnt=0, pend_cnt=0, ovf_err=0, rsp_valid=0. Asserting rst mid-transfer clears all state immediately, asynchronously.
- CMD_CHK_EN: master cmd {read=1, 0x8000_0010}, shadow cmd {read=1, 0x8000_0014} -> cmd_mismatch=1 one cycle after accept. Identical commands keep it 0. With the macro undefined, cmd_mismatch stays 0.
